axi_txn_checker: RTL and testbench

- Passive, synthesizable AXI4 transaction checker. Successor to the print-only TLX/AXI monitor.
- Snoops one AXI manager/subordinate pair on the SoC fabric side of the TLX bridge, parametrised in ID/LEN widths and outstanding depth.
- Tracks outstanding reads and writes, checks burst beat counts against LAST, and matches responses to issued IDs.
- Exposes sticky error flags, outstanding depths and completion counters to the testbench/debug logic. Never drives the bus.

---
 rtl/axi_txn_checker_if.sv | 44 ++++
 rtl/axi_txn_checker.sv | 215 +++++++++++++++++++++
 tb/tb_axi_txn_checker.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_txn_checker_if.sv
// AXI4 control-signal bundle snooped by axi_txn_checker: address, handshake,
// LAST and response fields only (no data/strobe lanes).
interface axi_txn_checker_if #(
  parameter int ID_W  = 4,
  parameter int LEN_W = 8
);
  logic [ID_W-1:0]  AWID;
  logic [LEN_W-1:0] AWLEN;
  logic             AWVALID;
  logic             AWREADY;
  logic             WLAST;
  logic             WVALID;
  logic             WREADY;
  logic [ID_W-1:0]  BID;
  logic [1:0]       BRESP;
  logic             BVALID;
  logic             BREADY;
  logic [ID_W-1:0]  ARID;
  logic [LEN_W-1:0] ARLEN;
  logic             ARVALID;
  logic             ARREADY;
  logic [ID_W-1:0]  RID;
  logic [1:0]       RRESP;
  logic             RLAST;
  logic             RVALID;
  logic             RREADY;

  modport master (
    output AWID, AWLEN, AWVALID, WLAST, WVALID, BREADY, ARID, ARLEN, ARVALID, RREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RRESP, RLAST, RVALID
  );

  modport slave (
    input  AWID, AWLEN, AWVALID, WLAST, WVALID, BREADY, ARID, ARLEN, ARVALID, RREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RRESP, RLAST, RVALID
  );

  // Passive observer: every signal is an input.
  modport monitor (
    input AWID, AWLEN, AWVALID, AWREADY, WLAST, WVALID, WREADY,
          BID, BRESP, BVALID, BREADY, ARID, ARLEN, ARVALID, ARREADY,
          RID, RRESP, RLAST, RVALID, RREADY
  );
endinterface

// File: rtl/axi_txn_checker.sv
// Passive AXI4 transaction checker: in-order write burst tracking, ID-matched read table,
// sticky error flags and completion counters. Define AXI_TXN_CHECKER_DISPLAY_EN for sim trace.
module axi_txn_checker #(
  parameter int ID_W    = 4,
  parameter int LEN_W   = 8,
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       CLK,
  input  logic                       RESETn,
  axi_txn_checker_if.monitor         bus,
  input  logic                       CLR_ERR,
  output logic [$clog2(MAX_OUT):0]   WR_OUTSTANDING,
  output logic [$clog2(MAX_OUT):0]   RD_OUTSTANDING,
  output logic [CNT_W-1:0]           WR_DONE_CNT,
  output logic [CNT_W-1:0]           RD_DONE_CNT,
  output logic [7:0]                 ERR_FLAGS,
  output logic                       ERR_IRQ
);
  localparam int AW_W   = $clog2(MAX_OUT);
  localparam int OUT_W  = AW_W + 1;
  localparam int BEAT_W = LEN_W + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  logic [LEN_W-1:0]  wq_len [MAX_OUT];
  logic [AW_W-1:0]   wq_head, wq_tail;
  logic [OUT_W-1:0]  wq_cnt, wq_cnt_n;
  logic [BEAT_W-1:0] w_beat, w_beat_n, w_beat_inc, head_beats;
  logic              wq_full, w_push, w_pop;
  logic [OUT_W-1:0]  wr_out_n;

  logic [MAX_OUT-1:0] rt_vld, rt_vld_n;
  logic [ID_W-1:0]    rt_id   [MAX_OUT];
  logic [ID_W-1:0]    rt_id_n [MAX_OUT];
  logic [LEN_W-1:0]   rt_len   [MAX_OUT];
  logic [LEN_W-1:0]   rt_len_n [MAX_OUT];
  logic [BEAT_W-1:0]  rt_beat   [MAX_OUT];
  logic [BEAT_W-1:0]  rt_beat_n [MAX_OUT];
  logic [OUT_W-1:0]   rt_age   [MAX_OUT];
  logic [OUT_W-1:0]   rt_age_n [MAX_OUT];
  logic               r_hit, r_free, r_last_ok;
  logic [AW_W-1:0]    r_idx, a_idx;
  logic [BEAT_W-1:0]  r_beat_inc, r_beats;
  logic [OUT_W-1:0]   same_cnt, rd_cnt_n;

  logic [7:0]         err_set, err_n;
  logic [CNT_W-1:0]   wr_done_n, rd_done_n;
  logic               unused_bid;

  // BID is not checked: the fabric returns write responses in issue order.
  assign unused_bid = ^bus.BID;

  always_comb begin
    aw_hs = bus.AWVALID & bus.AWREADY;
    w_hs  = bus.WVALID  & bus.WREADY;
    b_hs  = bus.BVALID  & bus.BREADY;
    ar_hs = bus.ARVALID & bus.ARREADY;
    r_hs  = bus.RVALID  & bus.RREADY;
    err_set = '0;

    wq_full    = (wq_cnt == OUT_W'(MAX_OUT));
    w_push     = aw_hs && !wq_full;
    w_pop      = 1'b0;
    w_beat_n   = w_beat;
    w_beat_inc = w_beat + BEAT_W'(1);
    head_beats = BEAT_W'(wq_len[wq_head]) + BEAT_W'(1);
    if (aw_hs && wq_full) err_set[3] = 1'b1;
    if (w_hs) begin
      if (wq_cnt == '0) begin
        err_set[7] = 1'b1;
      end else if (bus.WLAST || (w_beat_inc == head_beats)) begin
        w_pop    = 1'b1;
        w_beat_n = '0;
        if (bus.WLAST && (w_beat_inc != head_beats)) err_set[0] = 1'b1;
        if (!bus.WLAST) err_set[1] = 1'b1;
      end else begin
        w_beat_n = w_beat_inc;
      end
    end
    unique case ({w_push, w_pop})
      2'b10:   wq_cnt_n = wq_cnt + OUT_W'(1);
      2'b01:   wq_cnt_n = wq_cnt - OUT_W'(1);
      default: wq_cnt_n = wq_cnt;
    endcase

    wr_out_n = WR_OUTSTANDING;
    if (b_hs && (WR_OUTSTANDING == '0)) err_set[2] = 1'b1;
    if (w_push && !(b_hs && (WR_OUTSTANDING != '0))) begin
      if (WR_OUTSTANDING != '1) wr_out_n = WR_OUTSTANDING + OUT_W'(1);
    end else if (!w_push && b_hs && (WR_OUTSTANDING != '0)) begin
      wr_out_n = WR_OUTSTANDING - OUT_W'(1);
    end

    // Age 0 marks the oldest live read for its ID, so same-ID data retires in order.
    rt_vld_n  = rt_vld;
    rt_id_n   = rt_id;
    rt_len_n  = rt_len;
    rt_beat_n = rt_beat;
    rt_age_n  = rt_age;
    r_hit = 1'b0;
    r_idx = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (rt_vld[i] && (rt_id[i] == bus.RID) && (rt_age[i] == '0)) begin
        r_hit = 1'b1;
        r_idx = AW_W'(i);
      end
    end
    r_free     = 1'b0;
    r_beat_inc = rt_beat[r_idx] + BEAT_W'(1);
    r_beats    = BEAT_W'(rt_len[r_idx]) + BEAT_W'(1);
    r_last_ok  = (r_beat_inc == r_beats);
    if (r_hs) begin
      if (!r_hit) begin
        err_set[4] = 1'b1;
      end else if (bus.RLAST || r_last_ok) begin
        r_free             = 1'b1;
        rt_vld_n[r_idx]    = 1'b0;
        rt_beat_n[r_idx]   = '0;
        if (bus.RLAST != r_last_ok) err_set[5] = 1'b1;
        for (int j = 0; j < MAX_OUT; j++) begin
          if (rt_vld[j] && (AW_W'(j) != r_idx) && (rt_id[j] == bus.RID))
            rt_age_n[j] = rt_age[j] - OUT_W'(1);
        end
      end else begin
        rt_beat_n[r_idx] = r_beat_inc;
      end
    end

    a_idx    = '0;
    same_cnt = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (!rt_vld[i]) a_idx = AW_W'(i);
      if (rt_vld[i] && (rt_id[i] == bus.ARID)) same_cnt = same_cnt + OUT_W'(1);
    end
    if (r_free && (bus.ARID == bus.RID)) same_cnt = same_cnt - OUT_W'(1);
    if (ar_hs) begin
      if (&rt_vld) begin
        err_set[6] = 1'b1;
      end else begin
        rt_vld_n[a_idx]  = 1'b1;
        rt_id_n[a_idx]   = bus.ARID;
        rt_len_n[a_idx]  = bus.ARLEN;
        rt_beat_n[a_idx] = '0;
        rt_age_n[a_idx]  = same_cnt;
      end
    end
    rd_cnt_n = '0;
    for (int i = 0; i < MAX_OUT; i++) rd_cnt_n = rd_cnt_n + OUT_W'(rt_vld_n[i]);

    err_n     = (CLR_ERR ? 8'h00 : ERR_FLAGS) | err_set;
    wr_done_n = sat_inc(CLR_ERR ? '0 : WR_DONE_CNT, b_hs && (bus.BRESP == 2'b00));
    rd_done_n = sat_inc(CLR_ERR ? '0 : RD_DONE_CNT, r_hs && bus.RLAST && (bus.RRESP == 2'b00));
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wq_head        <= '0;
      wq_tail        <= '0;
      wq_cnt         <= '0;
      w_beat         <= '0;
      rt_vld         <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        wq_len[i]  <= '0;
        rt_id[i]   <= '0;
        rt_len[i]  <= '0;
        rt_beat[i] <= '0;
        rt_age[i]  <= '0;
      end
      WR_OUTSTANDING <= '0;
      RD_OUTSTANDING <= '0;
      WR_DONE_CNT    <= '0;
      RD_DONE_CNT    <= '0;
      ERR_FLAGS      <= '0;
      ERR_IRQ        <= 1'b0;
    end else begin
      if (w_push) begin
        wq_len[wq_tail] <= bus.AWLEN;
        wq_tail         <= wq_tail + AW_W'(1);
      end
      if (w_pop) wq_head <= wq_head + AW_W'(1);
      wq_cnt         <= wq_cnt_n;
      w_beat         <= w_beat_n;
      rt_vld         <= rt_vld_n;
      rt_id          <= rt_id_n;
      rt_len         <= rt_len_n;
      rt_beat        <= rt_beat_n;
      rt_age         <= rt_age_n;
      WR_OUTSTANDING <= wr_out_n;
      RD_OUTSTANDING <= rd_cnt_n;
      WR_DONE_CNT    <= wr_done_n;
      RD_DONE_CNT    <= rd_done_n;
      ERR_FLAGS      <= err_n;
      ERR_IRQ        <= |err_n;
    end
  end

`ifdef AXI_TXN_CHECKER_DISPLAY_EN
  always @(posedge CLK) begin
    if (RESETn) begin
      if (aw_hs) $display("WriteAddress Issued [ID=%0h LEN=%0d]", bus.AWID, bus.AWLEN);
      if (w_hs)  $display("WriteData Beat [LAST=%0b]", bus.WLAST);
      if (b_hs)  $display("WriteResponse Received [ID=%0h RESP=%0d]", bus.BID, bus.BRESP);
      if (ar_hs) $display("ReadAddress Issued [ID=%0h LEN=%0d]", bus.ARID, bus.ARLEN);
      if (r_hs)  $display("ReadData Beat [ID=%0h RESP=%0d LAST=%0b]", bus.RID, bus.RRESP, bus.RLAST);
      for (int i = 0; i < 8; i++)
        if (err_set[i]) $display("AXI ERR bit %0d at %0t", i, $time);
    end
  end
`endif
endmodule

// File: tb/tb_axi_txn_checker.sv
// Self-checking bench for axi_txn_checker: directed scenarios plus randomized traffic
// compared against a queue-based transaction model.
module tb_axi_txn_checker;
  localparam int ID_W = 4, LEN_W = 8, MAX_OUT = 8, CNT_W = 16;
  localparam int OUT_W = $clog2(MAX_OUT) + 1;
  localparam int OUT_MAX = (1 << OUT_W) - 1;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  logic CLR_ERR = 1'b0;
  logic [OUT_W-1:0] WR_OUTSTANDING, RD_OUTSTANDING;
  logic [CNT_W-1:0] WR_DONE_CNT, RD_DONE_CNT;
  logic [7:0]       ERR_FLAGS;
  logic             ERR_IRQ;

  axi_txn_checker_if #(.ID_W(ID_W), .LEN_W(LEN_W)) bus ();

  axi_txn_checker #(.ID_W(ID_W), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESETn(RESETn), .bus(bus), .CLR_ERR(CLR_ERR),
    .WR_OUTSTANDING(WR_OUTSTANDING), .RD_OUTSTANDING(RD_OUTSTANDING),
    .WR_DONE_CNT(WR_DONE_CNT), .RD_DONE_CNT(RD_DONE_CNT),
    .ERR_FLAGS(ERR_FLAGS), .ERR_IRQ(ERR_IRQ)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int passed = 0;

  // Reference model: write bursts as a queue of lengths, reads as an issue-ordered list.
  typedef struct { int id; int len; int beat; } rd_t;
  int        m_wq[$];
  rd_t       m_rd[$];
  int        m_wbeat, m_wrout, m_wdone, m_rdone;
  logic [7:0] m_err;

  task automatic model_reset();
    m_wq.delete(); m_rd.delete();
    m_wbeat = 0; m_wrout = 0; m_wdone = 0; m_rdone = 0; m_err = '0;
  endtask

  task automatic model_step();
    logic [7:0] e;
    bit aw, w, b, ar, r, found;
    int wsz, rsz, idx, inc, dec;
    rd_t t;
    e = '0;
    aw = bus.AWVALID && bus.AWREADY;  w = bus.WVALID && bus.WREADY;
    b  = bus.BVALID && bus.BREADY;    ar = bus.ARVALID && bus.ARREADY;
    r  = bus.RVALID && bus.RREADY;
    wsz = m_wq.size(); rsz = m_rd.size();
    if (w) begin
      if (wsz == 0) e[7] = 1'b1;
      else begin
        m_wbeat++;
        if (bus.WLAST && m_wbeat < m_wq[0] + 1) e[0] = 1'b1;
        if (!bus.WLAST && m_wbeat == m_wq[0] + 1) e[1] = 1'b1;
        if (bus.WLAST || m_wbeat == m_wq[0] + 1) begin
          void'(m_wq.pop_front());
          m_wbeat = 0;
        end
      end
    end
    inc = 0; dec = 0;
    if (aw) begin
      if (wsz >= MAX_OUT) e[3] = 1'b1;
      else begin m_wq.push_back(int'(bus.AWLEN)); inc = 1; end
    end
    if (b) begin
      if (m_wrout == 0) e[2] = 1'b1; else dec = 1;
    end
    m_wrout = m_wrout + inc - dec;
    if (m_wrout > OUT_MAX) m_wrout = OUT_MAX;
    if (r) begin
      found = 0; idx = 0;
      for (int k = 0; k < rsz; k++)
        if (!found && m_rd[k].id == int'(bus.RID)) begin found = 1; idx = k; end
      if (!found) e[4] = 1'b1;
      else begin
        t = m_rd[idx];
        t.beat++;
        if (bus.RLAST || t.beat == t.len + 1) begin
          if (!(bus.RLAST && t.beat == t.len + 1)) e[5] = 1'b1;
          m_rd.delete(idx);
        end else m_rd[idx] = t;
      end
    end
    if (ar) begin
      if (rsz >= MAX_OUT) e[6] = 1'b1;
      else begin t.id = int'(bus.ARID); t.len = int'(bus.ARLEN); t.beat = 0; m_rd.push_back(t); end
    end
    if (CLR_ERR) begin m_err = '0; m_wdone = 0; m_rdone = 0; end
    m_err = m_err | e;
    if (b && bus.BRESP == 2'b00 && m_wdone < (1 << CNT_W) - 1) m_wdone++;
    if (r && bus.RLAST && bus.RRESP == 2'b00 && m_rdone < (1 << CNT_W) - 1) m_rdone++;
  endtask

  task automatic tick();
    if (RESETn) model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.AWVALID = 0; bus.WVALID = 0; bus.BVALID = 0; bus.ARVALID = 0; bus.RVALID = 0;
    bus.AWREADY = 1; bus.WREADY = 1; bus.BREADY = 1; bus.ARREADY = 1; bus.RREADY = 1;
    bus.AWID = 0; bus.AWLEN = 0; bus.WLAST = 0; bus.BID = 0; bus.BRESP = 0;
    bus.ARID = 0; bus.ARLEN = 0; bus.RID = 0; bus.RRESP = 0; bus.RLAST = 0;
    CLR_ERR = 0;
  endtask

  task automatic test_reset();
    idle();
    model_reset();
    RESETn = 0;
    #12;
    total++; if (WR_OUTSTANDING !== '0) $display("FAIL rst_wr_out: got %0d want 0", WR_OUTSTANDING); else passed++;
    total++; if (RD_OUTSTANDING !== '0) $display("FAIL rst_rd_out: got %0d want 0", RD_OUTSTANDING); else passed++;
    total++; if (WR_DONE_CNT !== '0) $display("FAIL rst_wr_done: got %0d want 0", WR_DONE_CNT); else passed++;
    total++; if (RD_DONE_CNT !== '0) $display("FAIL rst_rd_done: got %0d want 0", RD_DONE_CNT); else passed++;
    total++; if (ERR_FLAGS !== 8'h00) $display("FAIL rst_err: got %02h want 00", ERR_FLAGS); else passed++;
    total++; if (ERR_IRQ !== 1'b0) $display("FAIL rst_irq: got %0b want 0", ERR_IRQ); else passed++;
    RESETn = 1;
    @(posedge CLK); #1;
  endtask

  task automatic test_write_basic();
    bus.AWVALID = 1; bus.AWID = 3; bus.AWLEN = 3; tick(); bus.AWVALID = 0;
    total++; if (WR_OUTSTANDING !== 4'd1) $display("FAIL wr_basic_out1: got %0d want 1", WR_OUTSTANDING); else passed++;
    bus.WVALID = 1;
    for (int i = 1; i <= 4; i++) begin bus.WLAST = (i == 4); tick(); end
    bus.WVALID = 0; bus.WLAST = 0;
    bus.BVALID = 1; bus.BID = 3; bus.BRESP = 0; tick(); bus.BVALID = 0;
    total++; if (WR_OUTSTANDING !== 4'd0) $display("FAIL wr_basic_out0: got %0d want 0", WR_OUTSTANDING); else passed++;
    total++; if (WR_DONE_CNT !== 16'd1) $display("FAIL wr_basic_done: got %0d want 1", WR_DONE_CNT); else passed++;
    total++; if (ERR_FLAGS !== 8'h00) $display("FAIL wr_basic_err: got %02h want 00", ERR_FLAGS); else passed++;
  endtask

  task automatic test_early_wlast_clear();
    bus.AWVALID = 1; bus.AWID = 1; bus.AWLEN = 3; tick(); bus.AWVALID = 0;
    bus.WVALID = 1; bus.WLAST = 0; tick(); bus.WLAST = 1; tick(); bus.WVALID = 0; bus.WLAST = 0;
    total++; if (ERR_FLAGS !== 8'h01) $display("FAIL early_wlast_err: got %02h want 01", ERR_FLAGS); else passed++;
    total++; if (ERR_IRQ !== 1'b1) $display("FAIL early_wlast_irq: got %0b want 1", ERR_IRQ); else passed++;
    CLR_ERR = 1; tick(); CLR_ERR = 0;
    total++; if (ERR_FLAGS !== 8'h00) $display("FAIL clr_err: got %02h want 00", ERR_FLAGS); else passed++;
    total++; if (WR_DONE_CNT !== 16'd0) $display("FAIL clr_wr_done: got %0d want 0", WR_DONE_CNT); else passed++;
    total++; if (ERR_IRQ !== 1'b0) $display("FAIL clr_irq: got %0b want 0", ERR_IRQ); else passed++;
    total++; if (WR_OUTSTANDING !== 4'd1) $display("FAIL clr_keeps_out: got %0d want 1", WR_OUTSTANDING); else passed++;
    bus.BVALID = 1; bus.BRESP = 0; tick(); bus.BVALID = 0;
    total++; if (WR_DONE_CNT !== 16'd1) $display("FAIL clr_then_b: got %0d want 1", WR_DONE_CNT); else passed++;
  endtask

  task automatic test_read_ids();
    logic [OUT_W-1:0] seq [4];
    bus.ARVALID = 1; bus.ARID = 1; bus.ARLEN = 1; tick();
    bus.ARID = 2; bus.ARLEN = 0; tick(); bus.ARVALID = 0;
    seq[0] = RD_OUTSTANDING;
    bus.RVALID = 1; bus.RID = 2; bus.RLAST = 1; bus.RRESP = 0; tick(); seq[1] = RD_OUTSTANDING;
    bus.RID = 1; bus.RLAST = 0; tick(); seq[2] = RD_OUTSTANDING;
    bus.RLAST = 1; tick(); seq[3] = RD_OUTSTANDING;
    bus.RVALID = 0; bus.RLAST = 0;
    total++; if ({seq[0], seq[1], seq[2], seq[3]} !== {4'd2, 4'd1, 4'd1, 4'd0})
      $display("FAIL rd_out_seq: got %0d,%0d,%0d,%0d want 2,1,1,0", seq[0], seq[1], seq[2], seq[3]); else passed++;
    total++; if (RD_DONE_CNT !== 16'd2) $display("FAIL rd_done: got %0d want 2", RD_DONE_CNT); else passed++;
    total++; if (ERR_FLAGS !== 8'h00) $display("FAIL rd_err: got %02h want 00", ERR_FLAGS); else passed++;
  endtask

  task automatic test_read_full_unmatched();
    bus.ARVALID = 1; bus.ARLEN = 0;
    for (int i = 0; i < MAX_OUT; i++) begin bus.ARID = ID_W'(i); tick(); end
    total++; if (RD_OUTSTANDING !== 4'd8) $display("FAIL rd_full_out: got %0d want 8", RD_OUTSTANDING); else passed++;
    bus.ARID = 4'h9; tick(); bus.ARVALID = 0;
    total++; if (ERR_FLAGS !== 8'h40) $display("FAIL rd_overflow_err: got %02h want 40", ERR_FLAGS); else passed++;
    total++; if (RD_OUTSTANDING !== 4'd8) $display("FAIL rd_overflow_out: got %0d want 8", RD_OUTSTANDING); else passed++;
    bus.RVALID = 1; bus.RID = 4'hF; bus.RLAST = 0; tick();
    total++; if (ERR_FLAGS !== 8'h50) $display("FAIL rd_unmatched_err: got %02h want 50", ERR_FLAGS); else passed++;
    bus.RLAST = 1;
    for (int i = 0; i < MAX_OUT; i++) begin bus.RID = ID_W'(i); tick(); end
    bus.RVALID = 0; bus.RLAST = 0;
    total++; if (RD_OUTSTANDING !== 4'd0) $display("FAIL rd_drain_out: got %0d want 0", RD_OUTSTANDING); else passed++;
    total++; if (RD_DONE_CNT !== 16'd10) $display("FAIL rd_drain_done: got %0d want 10", RD_DONE_CNT); else passed++;
    CLR_ERR = 1; tick(); CLR_ERR = 0;
    total++; if ({ERR_FLAGS, RD_DONE_CNT} !== 24'h0) $display("FAIL rd_clr: got %02h/%0d want 00/0", ERR_FLAGS, RD_DONE_CNT); else passed++;
  endtask

  task automatic test_aw_b_same_cycle();
    bus.AWVALID = 1; bus.AWLEN = 0; tick(); tick();
    total++; if (WR_OUTSTANDING !== 4'd2) $display("FAIL awb_pre: got %0d want 2", WR_OUTSTANDING); else passed++;
    bus.BVALID = 1; bus.BRESP = 0; tick(); bus.AWVALID = 0; bus.BVALID = 0;
    total++; if (WR_OUTSTANDING !== 4'd2) $display("FAIL awb_same: got %0d want 2", WR_OUTSTANDING); else passed++;
    bus.WVALID = 1; bus.WLAST = 1; tick(); tick(); tick(); bus.WVALID = 0; bus.WLAST = 0;
    bus.BVALID = 1; tick(); tick();
    total++; if ({WR_OUTSTANDING, WR_DONE_CNT} !== {4'd0, 16'd3}) $display("FAIL awb_drain: got %0d/%0d want 0/3", WR_OUTSTANDING, WR_DONE_CNT); else passed++;
    bus.BRESP = 2'b10; tick(); bus.BVALID = 0; bus.BRESP = 0;
    total++; if (ERR_FLAGS !== 8'h04) $display("FAIL b_underflow_err: got %02h want 04", ERR_FLAGS); else passed++;
    total++; if ({WR_OUTSTANDING, WR_DONE_CNT} !== {4'd0, 16'd3}) $display("FAIL b_underflow_cnt: got %0d/%0d want 0/3", WR_OUTSTANDING, WR_DONE_CNT); else passed++;
  endtask

  task automatic test_async_reset();
    bus.AWVALID = 1; bus.AWLEN = 3; tick(); bus.AWVALID = 0;
    bus.ARVALID = 1; bus.ARLEN = 2; tick(); bus.ARVALID = 0;
    bus.WVALID = 1; tick(); tick();
    #2; RESETn = 0; #1;
    total++; if ({WR_OUTSTANDING, RD_OUTSTANDING, WR_DONE_CNT, RD_DONE_CNT, ERR_FLAGS, ERR_IRQ} !== '0)
      $display("FAIL async_rst_zero: got %0d/%0d/%0d/%0d/%02h/%0b want all 0",
               WR_OUTSTANDING, RD_OUTSTANDING, WR_DONE_CNT, RD_DONE_CNT, ERR_FLAGS, ERR_IRQ); else passed++;
    idle(); model_reset();
    @(posedge CLK); #3; RESETn = 1;
    @(posedge CLK); #1;
    bus.AWVALID = 1; bus.AWID = 5; bus.AWLEN = 1; bus.ARVALID = 1; bus.ARID = 6; bus.ARLEN = 0; tick();
    bus.AWVALID = 0; bus.ARVALID = 0;
    bus.WVALID = 1; tick(); bus.WLAST = 1; tick(); bus.WVALID = 0; bus.WLAST = 0;
    bus.BVALID = 1; bus.RVALID = 1; bus.RID = 6; bus.RLAST = 1; tick(); bus.BVALID = 0; bus.RVALID = 0; bus.RLAST = 0;
    total++; if ({WR_OUTSTANDING, RD_OUTSTANDING, WR_DONE_CNT, RD_DONE_CNT, ERR_FLAGS} !== {4'd0, 4'd0, 16'd1, 16'd1, 8'h00})
      $display("FAIL post_rst_clean: got %0d/%0d/%0d/%0d/%02h want 0/0/1/1/00",
               WR_OUTSTANDING, RD_OUTSTANDING, WR_DONE_CNT, RD_DONE_CNT, ERR_FLAGS); else passed++;
  endtask

  task automatic test_random();
    int k, exp_b;
    bit lst;
    logic [OUT_W*2+CNT_W*2+9-1:0] got, want;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.AWVALID = ($urandom_range(99) < 30); bus.AWID = ID_W'($urandom_range(15)); bus.AWLEN = LEN_W'($urandom_range(3));
      bus.AWREADY = ($urandom_range(99) < 80);
      bus.WVALID = (m_wq.size() > 0) ? ($urandom_range(99) < 55) : ($urandom_range(99) < 3);
      lst = (m_wq.size() > 0) ? (m_wbeat + 1 == m_wq[0] + 1) : 1'b1;
      bus.WLAST = ($urandom_range(99) < 90) ? lst : 1'($urandom_range(1));
      bus.WREADY = ($urandom_range(99) < 80);
      bus.BVALID = (m_wrout > 0) ? ($urandom_range(99) < 30) : ($urandom_range(99) < 3);
      bus.BRESP = ($urandom_range(99) < 75) ? 2'b00 : 2'($urandom_range(3));
      bus.BREADY = ($urandom_range(99) < 85);
      bus.ARVALID = ($urandom_range(99) < 30); bus.ARID = ID_W'($urandom_range(3)); bus.ARLEN = LEN_W'($urandom_range(3));
      bus.ARREADY = ($urandom_range(99) < 80);
      if (m_rd.size() > 0 && $urandom_range(99) < 55) begin
        bus.RVALID = 1;
        k = $urandom_range(m_rd.size() - 1);
        bus.RID = ID_W'(m_rd[k].id);
        exp_b = -1;
        for (int q = 0; q < m_rd.size(); q++)
          if (exp_b < 0 && m_rd[q].id == m_rd[k].id) exp_b = q;
        lst = (m_rd[exp_b].beat + 1 == m_rd[exp_b].len + 1);
        bus.RLAST = ($urandom_range(99) < 90) ? lst : 1'($urandom_range(1));
      end else begin
        bus.RVALID = ($urandom_range(99) < 3); bus.RID = ID_W'($urandom_range(15)); bus.RLAST = 1'($urandom_range(1));
      end
      bus.RRESP = ($urandom_range(99) < 80) ? 2'b00 : 2'($urandom_range(3));
      bus.RREADY = ($urandom_range(99) < 80);
      CLR_ERR = ($urandom_range(99) < 4);
      tick();
      got  = {WR_OUTSTANDING, RD_OUTSTANDING, WR_DONE_CNT, RD_DONE_CNT, ERR_FLAGS, ERR_IRQ};
      want = {OUT_W'(m_wrout), OUT_W'(m_rd.size()), CNT_W'(m_wdone), CNT_W'(m_rdone), m_err, |m_err};
      total++;
      if (got !== want)
        $display("FAIL random cyc %0d: got wo=%0d ro=%0d wd=%0d rd=%0d err=%02h irq=%0b want wo=%0d ro=%0d wd=%0d rd=%0d err=%02h irq=%0b",
                 cyc, WR_OUTSTANDING, RD_OUTSTANDING, WR_DONE_CNT, RD_DONE_CNT, ERR_FLAGS, ERR_IRQ,
                 m_wrout, m_rd.size(), m_wdone, m_rdone, m_err, |m_err);
      else passed++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_early_wlast_clear();
    test_read_ids();
    test_read_full_unmatched();
    test_aw_b_same_cycle();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
